// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU core: op codes, FSM states
// and the flag bit positions used when packing flags onto uio_out.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // {carry, zero} sit at bits 1:0 to stay compatible with the wrapper
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/alu_seq_core_mul.sv
// Iterative shift-add multiplier: one partial product per cycle,
// WIDTH cycles per product; done marks the final iteration.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    // product is the accumulator after the current iteration, so the
    // core can capture it on the same edge that retires the last step
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle
// ops complete on the accept edge, MUL runs through the iterative unit.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_neg,
    output logic             flag_ovf
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state;
    logic [3:0]         flags;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl_w;
    logic [2*WIDTH-1:0] shr_w;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    function automatic logic [3:0] pack_flags(
        input logic [WIDTH-1:0] res,
        input logic             c,
        input logic             v
    );
        logic [3:0] f;
        f             = '0;
        f[FLAG_ZERO]  = (res == '0);
        f[FLAG_CARRY] = c;
        f[FLAG_NEG]   = res[WIDTH-1];
        f[FLAG_OVF]   = v;
        return f;
    endfunction

    assign flag_zero  = flags[FLAG_ZERO];
    assign flag_carry = flags[FLAG_CARRY];
    assign flag_neg   = flags[FLAG_NEG];
    assign flag_ovf   = flags[FLAG_OVF];

    // widened shifts expose the last bit shifted out at bit WIDTH / WIDTH-1
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sh      = b[SHW-1:0];
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_w   = {{WIDTH{1'b0}}, a} << sh;
        shr_w   = {a, {WIDTH{1'b0}}} >> sh;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1])
                       && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1])
                       && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[2*WIDTH-1:WIDTH];
                alu_c   = shr_w[WIDTH-1];
            end
            OP_MUL: alu_res = '0;
        endcase
    end

    assign mul_start = (state == IDLE) && in_valid && (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            state <= BUSY;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            flags     <= pack_flags(alu_res, alu_c, alu_v);
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        flags     <= pack_flags(mul_prod[WIDTH-1:0],
                                                |mul_prod[2*WIDTH-1:WIDTH],
                                                1'b0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed and random checks of alu_seq_core against an arithmetic
// reference model: results, flags, latency, backpressure and reset abort.
module tb_alu_seq_core;

    localparam int W = 8;
    localparam int M = 2 ** W;
    localparam int H = 2 ** (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         fz, fc, fn, fv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (fz),
        .flag_carry(fc),
        .flag_neg  (fn),
        .flag_ovf  (fv)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int o, input int x, input int y,
                         output int r, output int c, output int z,
                         output int n, output int v);
        int full, sx, sy, s, sh;
        sh = y % W;
        sx = (x >= H) ? x - M : x;
        sy = (y >= H) ? y - M : y;
        c = 0;
        v = 0;
        full = 0;
        case (o)
            0: begin
                full = x + y;
                c = (full >= M);
                s = sx + sy;
                v = (s >= H) || (s < -H);
            end
            1: begin
                full = x - y;
                c = (x < y);
                s = sx - sy;
                v = (s >= H) || (s < -H);
            end
            2: full = x & y;
            3: full = x | y;
            4: full = x ^ y;
            5: begin
                full = x * (2 ** sh);
                c = (sh > 0) ? ((x >> (W - sh)) & 1) : 0;
            end
            6: begin
                full = x / (2 ** sh);
                c = (sh > 0) ? ((x >> (sh - 1)) & 1) : 0;
            end
            default: begin
                full = x * y;
                c = (full >= M);
            end
        endcase
        r = ((full % M) + M) % M;
        z = (r == 0);
        n = (r >= H);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input int r, input int c,
                             input int z, input int n, input int v);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_result"}, 32'(result), 32'(r));
        chk({tag, "_carry"}, 32'(fc), 32'(c));
        chk({tag, "_zero"}, 32'(fz), 32'(z));
        chk({tag, "_neg"}, 32'(fn), 32'(n));
        chk({tag, "_ovf"}, 32'(fv), 32'(v));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(out_valid), 0);
        chk({tag, "_ack_ready"}, 32'(in_ready), 1);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input int x, input int y, input int r, input int c,
                       input int z, input int n, input int v);
        issue(o, W'(x), W'(y));
        wait_out(tag, (o == 3'd7) ? W + 1 : 1);
        check_out(tag, r, c, z, n, v);
        ack(tag);
    endtask

    initial begin
        int r, c, z, n, v;
        int o, x, y;

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'({fz, fc, fn, fv}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("add_200_100", 3'd0, 200, 100, 44, 1, 0, 0, 0);
        run("add_100_100", 3'd0, 100, 100, 200, 0, 0, 1, 1);
        run("sub_5_5", 3'd1, 5, 5, 0, 0, 1, 0, 0);
        run("sub_3_5", 3'd1, 3, 5, 254, 1, 0, 1, 0);
        run("mul_13_11", 3'd7, 13, 11, 143, 0, 0, 1, 0);
        run("mul_20_20", 3'd7, 20, 20, 144, 1, 0, 1, 0);
        run("shl_81_9", 3'd5, 8'h81, 9, 8'h02, 1, 0, 0, 0);
        run("shr_01_0", 3'd6, 8'h01, 0, 8'h01, 0, 0, 0, 0);

        // backpressure: held result, new operands ignored
        issue(3'd0, 8'd10, 8'd20);
        wait_out("bp", 1);
        check_out("bp", 30, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = 3'd1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check_out("bp_hold", 30, 0, 0, 0, 0);
            chk("bp_hold_in_ready", 32'(in_ready), 0);
        end
        a = 8'd50;
        b = 8'd8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("bp_next", 1);
        check_out("bp_next", 42, 0, 0, 0, 0);
        ack("bp_next");

        // reset during the 4th BUSY cycle of a multiply
        issue(3'd7, 8'd13, 8'd11);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_result", 32'(result), 0);
        chk("abort_flags", 32'({fz, fc, fn, fv}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_abort_add", 3'd0, 1, 1, 2, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            o = int'($urandom_range(0, 7));
            x = int'($urandom_range(0, M - 1));
            y = int'($urandom_range(0, M - 1));
            model(o, x, y, r, c, z, n, v);
            run($sformatf("rand%0d_op%0d", i, o), 3'(o), x, y, r, c, z, n, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
